ct_fcnvt_wb_ctrl: RTL and testbench

Writeback stage directly downstream of the fcnvt EX1–EX3 pipe control. It consumes ex3_pipedown plus the EX3 result payload and captures each result into a 4-entry in-order writeback queue. It presents the queue head to the vector register-file writeback arbiter with a valid/grant handshake. It returns a credit-based issue stall so results already in flight in EX1–EX3 always have a reserved slot.

---
 rtl/ct_fcnvt_wb_ctrl_pkg.sv | 26 ++
 rtl/ct_fcnvt_wb_ctrl_if.sv | 53 +++++
 rtl/ct_fcnvt_wb_ctrl_entry.sv | 54 +++++
 rtl/gated_clk_cell.sv | 34 +++
 rtl/ct_fcnvt_wb_ctrl.sv | 124 ++++++++++++
 tb/tb_ct_fcnvt_wb_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/ct_fcnvt_wb_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ct_fcnvt_wb_ctrl_pkg
// Description : Shared constants and types for the fcnvt writeback queue:
//               fflags bit positions and default payload geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package ct_fcnvt_wb_ctrl_pkg;

  // Exception flag bit positions inside the 5-bit fflags field
  localparam int FFLAG_NV    = 4;
  localparam int FFLAG_DZ    = 3;
  localparam int FFLAG_OF    = 2;
  localparam int FFLAG_UF    = 1;
  localparam int FFLAG_NX    = 0;
  localparam int FFLAG_WIDTH = 5;

  // Default payload geometry
  localparam int DEFAULT_DATA_WIDTH = 64;
  localparam int DEFAULT_PREG_WIDTH = 7;
  localparam int DEFAULT_DEPTH      = 4;

  typedef logic [FFLAG_WIDTH-1:0] fflags_t;

endpackage
`default_nettype wire

// File: rtl/ct_fcnvt_wb_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : ct_fcnvt_wb_ctrl_if
// Description : EX pipe-down / writeback arbiter bundle for the fcnvt
//               writeback queue. The slave modport is the queue itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface ct_fcnvt_wb_ctrl_if
  import ct_fcnvt_wb_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int PREG_WIDTH = DEFAULT_PREG_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH
) ();

  localparam int CNT_WIDTH = $clog2(DEPTH) + 1;

  // EX pipe side
  logic                  ex1_pipedown;
  logic                  ex2_pipedown;
  logic                  ex3_pipedown;
  logic [DATA_WIDTH-1:0] ex3_result;
  fflags_t               ex3_fflags;
  logic [PREG_WIDTH-1:0] ex3_dst_preg;
  logic                  rtu_yy_xx_flush;

  // Writeback arbiter side
  logic                  vfalu_wb_grant;
  logic                  fcnvt_wb_vld;
  logic [DATA_WIDTH-1:0] fcnvt_wb_data;
  fflags_t               fcnvt_wb_fflags;
  logic [PREG_WIDTH-1:0] fcnvt_wb_preg;
  logic                  fcnvt_issue_stall;
  logic [CNT_WIDTH-1:0]  fcnvt_wb_entry_cnt;

  modport slave (
    input  ex1_pipedown, ex2_pipedown, ex3_pipedown,
    input  ex3_result, ex3_fflags, ex3_dst_preg,
    input  rtu_yy_xx_flush, vfalu_wb_grant,
    output fcnvt_wb_vld, fcnvt_wb_data, fcnvt_wb_fflags, fcnvt_wb_preg,
    output fcnvt_issue_stall, fcnvt_wb_entry_cnt
  );

  modport master (
    output ex1_pipedown, ex2_pipedown, ex3_pipedown,
    output ex3_result, ex3_fflags, ex3_dst_preg,
    output rtu_yy_xx_flush, vfalu_wb_grant,
    input  fcnvt_wb_vld, fcnvt_wb_data, fcnvt_wb_fflags, fcnvt_wb_preg,
    input  fcnvt_issue_stall, fcnvt_wb_entry_cnt
  );

endinterface
`default_nettype wire

// File: rtl/ct_fcnvt_wb_ctrl_entry.sv
`default_nettype none
// ============================================================================
// Module      : ct_fcnvt_wb_entry
// Description : One writeback queue payload slot (result, fflags, dest preg)
//               clocked by its own gate that opens only when written.
// Revision    : 1.0 - initial release
// ============================================================================
module ct_fcnvt_wb_entry
  import ct_fcnvt_wb_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int PREG_WIDTH = DEFAULT_PREG_WIDTH
) (
  input  wire logic                  forever_cpuclk,
  input  wire logic                  cpurst_b,
  input  wire logic                  cp0_yy_clk_en,
  input  wire logic                  cp0_vfpu_icg_en,
  input  wire logic                  pad_yy_icg_scan_en,
  input  wire logic                  wr_en,
  input  wire logic [DATA_WIDTH-1:0] wr_data,
  input  wire fflags_t               wr_fflags,
  input  wire logic [PREG_WIDTH-1:0] wr_preg,
  output logic      [DATA_WIDTH-1:0] data,
  output fflags_t                    fflags,
  output logic      [PREG_WIDTH-1:0] preg
);

  logic w_entry_clk;

  gated_clk_cell x_entry_gated_clk (
    .clk_in             (forever_cpuclk),
    .global_en          (cp0_yy_clk_en),
    .module_en          (cp0_vfpu_icg_en),
    .local_en           (wr_en),
    .external_en        (1'b0),
    .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
    .clk_out            (w_entry_clk)
  );

  // Store the EX3 payload when this slot is the write target
  always_ff @(posedge w_entry_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      data   <= '0;
      fflags <= '0;
      preg   <= '0;
    end else if (wr_en) begin
      data   <= wr_data;
      fflags <= wr_fflags;
      preg   <= wr_preg;
    end
  end

endmodule
`default_nettype wire

// File: rtl/gated_clk_cell.sv
`default_nettype none
// ============================================================================
// Module      : gated_clk_cell
// Description : Latch-based integrated clock gate. The clock runs when the
//               global enable is set and either the module or local enable
//               is set, or when the external or scan override is set.
// Revision    : 1.0 - initial release
// ============================================================================
module gated_clk_cell (
  input  wire logic clk_in,
  input  wire logic global_en,
  input  wire logic module_en,
  input  wire logic local_en,
  input  wire logic external_en,
  input  wire logic pad_yy_icg_scan_en,
  output logic      clk_out
);

  logic w_clk_en_bf_latch;
  logic r_clk_en_af_latch;

  assign w_clk_en_bf_latch = (global_en & (module_en | local_en)) | external_en;

  // Capture the enable during the low phase so clk_out never glitches
  always_latch begin
    if (!clk_in) begin
      r_clk_en_af_latch <= w_clk_en_bf_latch | pad_yy_icg_scan_en;
    end
  end

  assign clk_out = clk_in & r_clk_en_af_latch;

endmodule
`default_nettype wire

// File: rtl/ct_fcnvt_wb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ct_fcnvt_wb_ctrl
// Description : fcnvt writeback stage. Captures EX3 results into an in-order
//               queue, presents the head to the VRF writeback arbiter, and
//               raises a credit stall so every in-flight op has a slot.
// Revision    : 1.0 - initial release
// ============================================================================
module ct_fcnvt_wb_ctrl
  import ct_fcnvt_wb_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int PREG_WIDTH = DEFAULT_PREG_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH
) (
  input  wire logic          forever_cpuclk,
  input  wire logic          cpurst_b,
  input  wire logic          cp0_yy_clk_en,
  input  wire logic          cp0_vfpu_icg_en,
  input  wire logic          pad_yy_icg_scan_en,
  ct_fcnvt_wb_ctrl_if.slave  bus
);

  localparam int PTR_WIDTH = $clog2(DEPTH);
  localparam int CNT_WIDTH = PTR_WIDTH + 1;
  localparam logic [CNT_WIDTH:0] C_CREDIT_LIMIT = (CNT_WIDTH + 1)'(DEPTH);

  logic [PTR_WIDTH-1:0]  r_rptr;
  logic [PTR_WIDTH-1:0]  r_wptr;
  logic [CNT_WIDTH-1:0]  r_cnt;

  logic                  w_vld;
  logic                  w_enq;
  logic                  w_deq;
  logic                  w_ctrl_clk_en;
  logic                  w_ctrl_clk;
  logic [CNT_WIDTH:0]    w_credit;

  logic [DEPTH-1:0]      w_ent_wr_en;
  logic [DATA_WIDTH-1:0] w_ent_data   [DEPTH];
  fflags_t               w_ent_fflags [DEPTH];
  logic [PREG_WIDTH-1:0] w_ent_preg   [DEPTH];

  // Flush wins over both queue operations; grant only counts with a valid head
  assign w_vld = (r_cnt != '0);
  assign w_enq = bus.ex3_pipedown & ~bus.rtu_yy_xx_flush;
  assign w_deq = w_vld & bus.vfalu_wb_grant & ~bus.rtu_yy_xx_flush;

  assign w_ctrl_clk_en = bus.ex3_pipedown | w_vld | bus.rtu_yy_xx_flush;

  gated_clk_cell x_ctrl_gated_clk (
    .clk_in             (forever_cpuclk),
    .global_en          (cp0_yy_clk_en),
    .module_en          (cp0_vfpu_icg_en),
    .local_en           (w_ctrl_clk_en),
    .external_en        (1'b0),
    .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
    .clk_out            (w_ctrl_clk)
  );

  // Pointer and occupancy update; enqueue/dequeue may coincide even when full
  always_ff @(posedge w_ctrl_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_rptr <= '0;
      r_wptr <= '0;
      r_cnt  <= '0;
    end else if (bus.rtu_yy_xx_flush) begin
      r_rptr <= '0;
      r_wptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_enq) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_deq) begin
        r_rptr <= r_rptr + 1'b1;
      end
      unique case ({w_enq, w_deq})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Reserve a slot for every op already in EX1..EX3
  assign w_credit = {1'b0, r_cnt}
                  + (CNT_WIDTH + 1)'(bus.ex1_pipedown)
                  + (CNT_WIDTH + 1)'(bus.ex2_pipedown)
                  + (CNT_WIDTH + 1)'(bus.ex3_pipedown);

  assign bus.fcnvt_issue_stall  = (w_credit >= C_CREDIT_LIMIT);
  assign bus.fcnvt_wb_vld       = w_vld;
  assign bus.fcnvt_wb_entry_cnt = r_cnt;

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    assign w_ent_wr_en[g] = w_enq & (r_wptr == PTR_WIDTH'(g));

    ct_fcnvt_wb_entry #(
      .DATA_WIDTH (DATA_WIDTH),
      .PREG_WIDTH (PREG_WIDTH)
    ) x_entry (
      .forever_cpuclk     (forever_cpuclk),
      .cpurst_b           (cpurst_b),
      .cp0_yy_clk_en      (cp0_yy_clk_en),
      .cp0_vfpu_icg_en    (cp0_vfpu_icg_en),
      .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
      .wr_en              (w_ent_wr_en[g]),
      .wr_data            (bus.ex3_result),
      .wr_fflags          (bus.ex3_fflags),
      .wr_preg            (bus.ex3_dst_preg),
      .data               (w_ent_data[g]),
      .fflags             (w_ent_fflags[g]),
      .preg               (w_ent_preg[g])
    );
  end

  // Head payload comes straight from the slot at the read pointer
  assign bus.fcnvt_wb_data   = w_ent_data[r_rptr];
  assign bus.fcnvt_wb_fflags = w_ent_fflags[r_rptr];
  assign bus.fcnvt_wb_preg   = w_ent_preg[r_rptr];

endmodule
`default_nettype wire

// File: tb/tb_ct_fcnvt_wb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ct_fcnvt_wb_ctrl
// Description : Self-checking bench for the fcnvt writeback queue. Expected
//               results are queued as ops are driven into EX3 and popped when
//               the arbiter grants the head.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ct_fcnvt_wb_ctrl;
  import ct_fcnvt_wb_ctrl_pkg::*;

  localparam int DW    = 64;
  localparam int PW    = 7;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [4:0]    ff;
    logic [PW-1:0] preg;
  } wb_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic clk_en;
  logic vfpu_icg_en;
  logic scan_en;

  int   checks = 0;
  int   errors = 0;
  wb_t  sb[$];

  ct_fcnvt_wb_ctrl_if #(.DATA_WIDTH(DW), .PREG_WIDTH(PW), .DEPTH(DEPTH)) bus ();

  ct_fcnvt_wb_ctrl #(.DATA_WIDTH(DW), .PREG_WIDTH(PW), .DEPTH(DEPTH)) dut (
    .forever_cpuclk     (clk),
    .cpurst_b           (rst_n),
    .cp0_yy_clk_en      (clk_en),
    .cp0_vfpu_icg_en    (vfpu_icg_en),
    .pad_yy_icg_scan_en (scan_en),
    .bus                (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic wb_t mk_op(input int k);
    wb_t r;
    r.data = 64'hA5A5_0000_0000_0000 | 64'(k);
    r.ff   = 5'(k);
    r.preg = 7'(k + 20);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e1, input logic e2, input logic e3,
                       input wb_t pl, input logic fl, input logic gr);
    bus.ex1_pipedown   = e1;
    bus.ex2_pipedown   = e2;
    bus.ex3_pipedown   = e3;
    bus.ex3_result     = pl.data;
    bus.ex3_fflags     = pl.ff;
    bus.ex3_dst_preg   = pl.preg;
    bus.rtu_yy_xx_flush = fl;
    bus.vfalu_wb_grant = gr;
    if (e3 && !fl) sb.push_back(pl);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  // Scoreboard monitor: occupancy, valid, stall and in-order writeback
  int  m_pend;
  int  m_cnt;
  int  m_credit;
  wb_t m_exp;
  wb_t m_act;
  always @(negedge clk) begin
    if (rst_n) begin
      m_pend   = (bus.ex3_pipedown && !bus.rtu_yy_xx_flush) ? 1 : 0;
      m_cnt    = sb.size() - m_pend;
      m_credit = m_cnt + int'(bus.ex1_pipedown) + int'(bus.ex2_pipedown) + int'(bus.ex3_pipedown);
      checks++;
      if (bus.fcnvt_wb_entry_cnt !== CW'(m_cnt) || bus.fcnvt_wb_vld !== (m_cnt != 0)) begin
        errors++;
        $display("FAIL sb_occupancy: cnt=%0d vld=%0b, expected cnt=%0d vld=%0b",
                 bus.fcnvt_wb_entry_cnt, bus.fcnvt_wb_vld, m_cnt, (m_cnt != 0));
      end
      checks++;
      if (bus.fcnvt_issue_stall !== (m_credit >= DEPTH)) begin
        errors++;
        $display("FAIL sb_stall: stall=%0b, expected %0b (credit %0d)",
                 bus.fcnvt_issue_stall, (m_credit >= DEPTH), m_credit);
      end
      if (bus.ex3_pipedown && !bus.rtu_yy_xx_flush && !bus.vfalu_wb_grant &&
          bus.fcnvt_wb_entry_cnt == CW'(DEPTH)) begin
        errors++;
        $display("FAIL prop_no_full_enq: enqueue into full queue, cnt=%0d expected <%0d",
                 bus.fcnvt_wb_entry_cnt, DEPTH);
      end
      if (bus.rtu_yy_xx_flush) begin
        sb.delete();
      end else if (bus.vfalu_wb_grant && m_cnt > 0) begin
        m_exp = sb.pop_front();
        m_act = '{data: bus.fcnvt_wb_data, ff: bus.fcnvt_wb_fflags, preg: bus.fcnvt_wb_preg};
        checks++;
        if (m_act !== m_exp) begin
          errors++;
          $display("FAIL sb_writeback: got data=%h ff=%b preg=%0d, expected data=%h ff=%b preg=%0d",
                   m_act.data, m_act.ff, m_act.preg, m_exp.data, m_exp.ff, m_exp.preg);
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    repeat (3) tick();
    checks++;
    if (bus.fcnvt_wb_vld !== 1'b0 || bus.fcnvt_issue_stall !== 1'b0 || bus.fcnvt_wb_entry_cnt !== '0) begin
      errors++;
      $display("FAIL reset_hold: vld=%0b stall=%0b cnt=%0d, expected 0 0 0",
               bus.fcnvt_wb_vld, bus.fcnvt_issue_stall, bus.fcnvt_wb_entry_cnt);
    end
    rst_n = 1'b1;
    repeat (2) tick();
    checks++;
    if (bus.fcnvt_wb_vld !== 1'b0 || bus.fcnvt_issue_stall !== 1'b0 || bus.fcnvt_wb_entry_cnt !== '0) begin
      errors++;
      $display("FAIL reset_idle: vld=%0b stall=%0b cnt=%0d, expected 0 0 0",
               bus.fcnvt_wb_vld, bus.fcnvt_issue_stall, bus.fcnvt_wb_entry_cnt);
    end
  endtask

  task automatic test_single_op();
    wb_t op;
    op.data = 64'h3FF0_0000_0000_0000;
    op.ff   = 5'b00001 << FFLAG_NX;
    op.preg = 7'd12;
    repeat (8) tick();
    drive(1'b0, 1'b0, 1'b1, op, 1'b0, 1'b0);
    tick();
    idle();
    checks++;
    if (bus.fcnvt_wb_vld !== 1'b1 || bus.fcnvt_wb_data !== 64'h3FF0_0000_0000_0000 ||
        bus.fcnvt_wb_fflags !== 5'b00001 || bus.fcnvt_wb_preg !== 7'd12) begin
      errors++;
      $display("FAIL single_head: vld=%0b data=%h ff=%b preg=%0d, expected 1 3ff0000000000000 00001 12",
               bus.fcnvt_wb_vld, bus.fcnvt_wb_data, bus.fcnvt_wb_fflags, bus.fcnvt_wb_preg);
    end
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    tick();
    idle();
    checks++;
    if (bus.fcnvt_wb_vld !== 1'b0) begin
      errors++;
      $display("FAIL single_drain: vld=%0b, expected 0", bus.fcnvt_wb_vld);
    end
  endtask

  task automatic test_backpressure();
    logic p1 = 1'b0, p2 = 1'b0, p3 = 1'b0;
    int   id1 = 0, id2 = 0, id3 = 0;
    int   issued = 0;
    logic issue_next = 1'b1;
    for (int cyc = 0; cyc < 7; cyc++) begin
      p3 = p2; id3 = id2;
      p2 = p1; id2 = id1;
      if (issue_next && issued < DEPTH) begin
        p1 = 1'b1; id1 = issued; issued++;
      end else begin
        p1 = 1'b0;
      end
      drive(p1, p2, p3, mk_op(id3), 1'b0, 1'b0);
      #1;
      if (cyc == 2 || cyc == 3) begin
        checks++;
        if (bus.fcnvt_issue_stall !== (cyc == 3)) begin
          errors++;
          $display("FAIL bp_stall_rise: cyc=%0d stall=%0b, expected %0b",
                   cyc, bus.fcnvt_issue_stall, (cyc == 3));
        end
      end
      issue_next = !bus.fcnvt_issue_stall;
      tick();
    end
    idle();
    checks++;
    if (bus.fcnvt_wb_entry_cnt !== CW'(DEPTH) || bus.fcnvt_issue_stall !== 1'b1) begin
      errors++;
      $display("FAIL bp_full: cnt=%0d stall=%0b, expected 4 1",
               bus.fcnvt_wb_entry_cnt, bus.fcnvt_issue_stall);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (bus.fcnvt_wb_vld !== 1'b1 || bus.fcnvt_wb_data !== mk_op(0).data ||
          bus.fcnvt_wb_preg !== mk_op(0).preg) begin
        errors++;
        $display("FAIL bp_hold: cyc=%0d vld=%0b data=%h preg=%0d, expected 1 %h %0d",
                 i, bus.fcnvt_wb_vld, bus.fcnvt_wb_data, bus.fcnvt_wb_preg,
                 mk_op(0).data, mk_op(0).preg);
      end
    end
    for (int k = 0; k < DEPTH; k++) begin
      checks++;
      if (bus.fcnvt_wb_vld !== 1'b1 || bus.fcnvt_wb_data !== mk_op(k).data) begin
        errors++;
        $display("FAIL bp_order: slot=%0d vld=%0b data=%h, expected 1 %h",
                 k, bus.fcnvt_wb_vld, bus.fcnvt_wb_data, mk_op(k).data);
      end
      drive(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
      tick();
    end
    idle();
    checks++;
    if (bus.fcnvt_wb_vld !== 1'b0) begin
      errors++;
      $display("FAIL bp_empty: vld=%0b, expected 0", bus.fcnvt_wb_vld);
    end
  endtask

  task automatic test_full_concurrent();
    for (int k = 0; k < DEPTH; k++) begin
      drive(1'b0, 1'b0, 1'b1, mk_op(100 + k), 1'b0, 1'b0);
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 1'b1, mk_op(200 + k), 1'b0, 1'b1);
      tick();
      checks++;
      if (bus.fcnvt_wb_entry_cnt !== CW'(DEPTH)) begin
        errors++;
        $display("FAIL full_concurrent_cnt: step=%0d cnt=%0d, expected %0d",
                 k, bus.fcnvt_wb_entry_cnt, DEPTH);
      end
    end
    idle();
    checks++;
    if (bus.fcnvt_wb_data !== mk_op(103).data) begin
      errors++;
      $display("FAIL full_concurrent_head: data=%h, expected %h",
               bus.fcnvt_wb_data, mk_op(103).data);
    end
    for (int k = 0; k < DEPTH; k++) begin
      drive(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
      tick();
    end
    idle();
    checks++;
    if (bus.fcnvt_wb_vld !== 1'b0) begin
      errors++;
      $display("FAIL full_concurrent_drain: vld=%0b, expected 0", bus.fcnvt_wb_vld);
    end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 1'b1, mk_op(300 + k), 1'b0, 1'b0);
      tick();
    end
    checks++;
    if (bus.fcnvt_wb_entry_cnt !== CW'(3)) begin
      errors++;
      $display("FAIL flush_pre: cnt=%0d, expected 3", bus.fcnvt_wb_entry_cnt);
    end
    drive(1'b0, 1'b0, 1'b1, mk_op(399), 1'b1, 1'b1);
    tick();
    idle();
    checks++;
    if (bus.fcnvt_wb_entry_cnt !== '0 || bus.fcnvt_wb_vld !== 1'b0 || bus.fcnvt_issue_stall !== 1'b0) begin
      errors++;
      $display("FAIL flush_clear: cnt=%0d vld=%0b stall=%0b, expected 0 0 0",
               bus.fcnvt_wb_entry_cnt, bus.fcnvt_wb_vld, bus.fcnvt_issue_stall);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (bus.fcnvt_wb_vld !== 1'b0) begin
        errors++;
        $display("FAIL flush_ghost: cyc=%0d vld=%0b, expected 0", i, bus.fcnvt_wb_vld);
      end
    end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b0, 1'b1, mk_op(400 + k), 1'b0, 1'b0);
      tick();
    end
    idle();
    checks++;
    if (bus.fcnvt_wb_entry_cnt !== CW'(2) || bus.fcnvt_wb_vld !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre: cnt=%0d vld=%0b, expected 2 1",
               bus.fcnvt_wb_entry_cnt, bus.fcnvt_wb_vld);
    end
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    checks++;
    if (bus.fcnvt_wb_entry_cnt !== '0 || bus.fcnvt_wb_vld !== 1'b0 || bus.fcnvt_issue_stall !== 1'b0) begin
      errors++;
      $display("FAIL areset_clear: cnt=%0d vld=%0b stall=%0b, expected 0 0 0",
               bus.fcnvt_wb_entry_cnt, bus.fcnvt_wb_vld, bus.fcnvt_issue_stall);
    end
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (bus.fcnvt_wb_vld !== 1'b0) begin
        errors++;
        $display("FAIL areset_quiet: cyc=%0d vld=%0b, expected 0", i, bus.fcnvt_wb_vld);
      end
    end
    drive(1'b0, 1'b0, 1'b1, mk_op(500), 1'b0, 1'b0);
    tick();
    idle();
    checks++;
    if (bus.fcnvt_wb_vld !== 1'b1 || bus.fcnvt_wb_data !== mk_op(500).data) begin
      errors++;
      $display("FAIL areset_resume: vld=%0b data=%h, expected 1 %h",
               bus.fcnvt_wb_vld, bus.fcnvt_wb_data, mk_op(500).data);
    end
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    tick();
    idle();
    tick();
  endtask

  initial begin
    clk_en      = 1'b1;
    vfpu_icg_en = 1'b0;
    scan_en     = 1'b0;
    test_reset();
    test_single_op();
    test_backpressure();
    test_full_concurrent();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
